// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: shadowed frame capture, leading-zero
// suppression, dead-time blanking and PWM dimming, all outputs registered.

module seg7_digit_lane #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       en,
  input  logic       lz,
  input  logic       hi_blank,
  output logic [7:0] seg,
  output logic       on
);
  logic       supp;
  logic [6:0] glyph;

  // The least significant digit always shows, so an all-zero value reads "0".
  assign supp = lz & (nibble == 4'h0) & hi_blank & ~IS_LSD;
  assign on   = en & ~supp;

  always_comb begin
    glyph = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    seg = {dp & ~supp, glyph};
  end
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int SLOT_CYCLES    = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter int BR_W           = 3,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic [BR_W-1:0]         brightness,
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_L   = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                         state, state_nxt;
  logic [SW-1:0]                  slot_cnt, slot_nxt;
  logic [DW-1:0]                  digit_idx, idx_nxt;
  logic [BR_W-1:0]                pwm_cnt;
  logic                           cap_pend;
  logic [NUM_DIGITS-1:0][3:0]     sh_dig;
  logic [NUM_DIGITS-1:0]          sh_dp, sh_en;
  logic                           sh_lz;
  logic [NUM_DIGITS-1:0][7:0]     lane_seg;
  logic [NUM_DIGITS-1:0]          lane_on;
  logic [NUM_DIGITS:1]            hi_blank_c;
  logic                           slot_wrap, frame_wrap, drive;
  logic [7:0]                     seg_nxt, seg_q;
  logic [NUM_DIGITS-1:0]          an_nxt, an_q;
  logic                           fd_q;

  // hi_blank_c[i]: every digit at index >= i is zero or disabled.
  assign hi_blank_c[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    if (i > 0) begin : g_chain
      assign hi_blank_c[i] = hi_blank_c[i+1] & ((sh_dig[i] == 4'h0) | ~sh_en[i]);
    end
    seg7_digit_lane #(.IS_LSD(i == 0)) u_lane (
      .nibble   (sh_dig[i]),
      .dp       (sh_dp[i]),
      .en       (sh_en[i]),
      .lz       (sh_lz),
      .hi_blank (hi_blank_c[i+1]),
      .seg      (lane_seg[i]),
      .on       (lane_on[i])
    );
  end

  always_comb begin
    slot_wrap  = (slot_cnt == SLOT_LAST);
    frame_wrap = slot_wrap & (digit_idx == DIG_LAST);
    slot_nxt   = slot_wrap ? '0 : slot_cnt + 1'b1;
    idx_nxt    = digit_idx;
    if (slot_wrap) idx_nxt = (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
    state_nxt  = (slot_nxt < BLANK_L) ? S_BLANK : S_DRIVE;
    // Brightness is live so dimming responds within one PWM period.
    drive      = (state == S_DRIVE) & lane_on[digit_idx] &
                 ((pwm_cnt < brightness) | (&brightness));
    seg_nxt    = drive ? lane_seg[digit_idx] : 8'h00;
    an_nxt     = '0;
    an_nxt[digit_idx] = drive;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_BLANK;
      slot_cnt  <= '0;
      digit_idx <= '0;
      pwm_cnt   <= '0;
      cap_pend  <= 1'b1;
      sh_dig    <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      sh_lz     <= 1'b0;
      seg_q     <= '0;
      an_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_nxt;
      digit_idx <= idx_nxt;
      pwm_cnt   <= pwm_cnt + 1'b1;
      cap_pend  <= 1'b0;
      if (cap_pend | frame_wrap) begin
        sh_dig <= digits;
        sh_dp  <= dp_in;
        sh_en  <= digit_en;
        sh_lz  <= lz_suppress;
      end
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
      fd_q  <= frame_wrap;
    end
  end

  assign segments   = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign anodes     = (AN_ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 8-cycle slots, 2 blank cycles, active-low anodes.

module tb_seg7_scan_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in, digit_en;
  logic        lz_suppress;
  logic [2:0]  brightness;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [3:0] cap_an [32];
  logic [7:0] cap_sg [32];
  logic       cap_fd [32];

  always #5 clock = ~clock;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .BR_W(3),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .digits(digits), .dp_in(dp_in),
    .digit_en(digit_en), .lz_suppress(lz_suppress), .brightness(brightness),
    .segments(segments), .anodes(anodes), .frame_done(frame_done)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic grab_frame;
    for (int c = 0; c < 32; c++) begin
      step();
      cap_an[c] = anodes;
      cap_sg[c] = segments;
      cap_fd[c] = frame_done;
    end
  endtask

  // Hand-written hex glyph table, gfedcba.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
      4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
      4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
      4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  task automatic test_reset;
    logic [3:0] ea;
    logic [7:0] es;
    digits = 16'h0000; dp_in = 4'b0000; digit_en = 4'b1111;
    lz_suppress = 1'b0; brightness = 3'd7;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (anodes !== 4'hF || segments !== 8'h00 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold k=%0d got an=%b seg=%h fd=%b exp an=1111 seg=00 fd=0",
                 k, anodes, segments, frame_done);
      end
    end
    reset = 1'b0;
    grab_frame();
    for (int c = 0; c < 32; c++) begin
      ea = 4'hF; es = 8'h00;
      if (c % 8 >= 2) begin ea[c/8] = 1'b0; es = 8'h3F; end
      checks++;
      if (cap_an[c] !== ea || cap_sg[c] !== es || cap_fd[c] !== (c == 31)) begin
        failures++;
        $display("FAIL scan_first c=%0d got an=%b seg=%h fd=%b exp an=%b seg=%h fd=%b",
                 c, cap_an[c], cap_sg[c], cap_fd[c], ea, es, (c == 31));
      end
    end
    grab_frame();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (cap_fd[c] !== (c == 31)) begin
        failures++;
        $display("FAIL frame_done_period c=%0d got=%b exp=%b", c, cap_fd[c], (c == 31));
      end
    end
  endtask

  task automatic test_lz_dp;
    logic [3:0] ea;
    logic [7:0] es;
    logic [7:0] g [4];
    digits = 16'h00A5; lz_suppress = 1'b1; dp_in = 4'b0010; brightness = 3'd7;
    grab_frame();
    grab_frame();
    g[0] = 8'h6D; g[1] = 8'hF7; g[2] = 8'h00; g[3] = 8'h00;
    for (int c = 0; c < 32; c++) begin
      ea = 4'hF; es = 8'h00;
      if (c % 8 >= 2 && c / 8 < 2) begin ea[c/8] = 1'b0; es = g[c/8]; end
      checks++;
      if (cap_an[c] !== ea || cap_sg[c] !== es) begin
        failures++;
        $display("FAIL lz_on c=%0d got an=%b seg=%h exp an=%b seg=%h", c, cap_an[c], cap_sg[c], ea, es);
      end
    end
    lz_suppress = 1'b0;
    grab_frame();
    grab_frame();
    g[2] = 8'h3F; g[3] = 8'h3F;
    for (int c = 0; c < 32; c++) begin
      ea = 4'hF; es = 8'h00;
      if (c % 8 >= 2) begin ea[c/8] = 1'b0; es = g[c/8]; end
      checks++;
      if (cap_an[c] !== ea || cap_sg[c] !== es) begin
        failures++;
        $display("FAIL lz_off c=%0d got an=%b seg=%h exp an=%b seg=%h", c, cap_an[c], cap_sg[c], ea, es);
      end
    end
  endtask

  task automatic test_pwm;
    logic [3:0] ea;
    int on_cnt;
    brightness = 3'd3;
    grab_frame();
    on_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      // pwm_cnt equals slot_cnt here: both start at 0 and share period 8.
      ea = 4'hF;
      if (c % 8 == 2) ea[c/8] = 1'b0;
      if (cap_an[c] !== 4'hF) on_cnt++;
      checks++;
      if (cap_an[c] !== ea) begin
        failures++;
        $display("FAIL pwm3 c=%0d got an=%b exp an=%b", c, cap_an[c], ea);
      end
    end
    checks++;
    if (on_cnt !== 4) begin
      failures++;
      $display("FAIL pwm3_count got=%0d exp=4", on_cnt);
    end
    brightness = 3'd0;
    grab_frame();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (cap_an[c] !== 4'hF || cap_sg[c] !== 8'h00) begin
        failures++;
        $display("FAIL pwm0 c=%0d got an=%b seg=%h exp an=1111 seg=00", c, cap_an[c], cap_sg[c]);
      end
    end
    brightness = 3'd7;
  endtask

  task automatic test_capture;
    logic [7:0] es;
    logic [7:0] g [4];
    digits = 16'h1234; dp_in = 4'b0000;
    grab_frame();
    g[0] = 8'h66; g[1] = 8'h4F; g[2] = 8'h5B; g[3] = 8'h06;
    for (int c = 0; c < 32; c++) begin
      if (c == 12) digits = 16'h5678;
      step();
      es = (c % 8 >= 2) ? g[c/8] : 8'h00;
      checks++;
      if (segments !== es) begin
        failures++;
        $display("FAIL no_tear c=%0d got seg=%h exp seg=%h", c, segments, es);
      end
    end
    grab_frame();
    g[0] = glyph(4'h8); g[1] = glyph(4'h7); g[2] = glyph(4'h6); g[3] = glyph(4'h5);
    for (int c = 0; c < 32; c++) begin
      es = (c % 8 >= 2) ? g[c/8] : 8'h00;
      checks++;
      if (cap_sg[c] !== es) begin
        failures++;
        $display("FAIL new_frame c=%0d got seg=%h exp seg=%h", c, cap_sg[c], es);
      end
    end
  endtask

  task automatic test_digit_en;
    logic [3:0] ea;
    digit_en = 4'b1011;
    grab_frame();
    grab_frame();
    for (int c = 0; c < 32; c++) begin
      ea = 4'hF;
      if (c % 8 >= 2 && c / 8 != 2) ea[c/8] = 1'b0;
      checks++;
      if (cap_an[c] !== ea) begin
        failures++;
        $display("FAIL digit_en c=%0d got an=%b exp an=%b", c, cap_an[c], ea);
      end
    end
    digit_en = 4'b1111;
    grab_frame();
  endtask

  task automatic test_reset_mid;
    logic [3:0] ea;
    logic [7:0] es;
    logic [7:0] g [4];
    for (int c = 0; c < 20; c++) step();
    checks++;
    if (anodes !== 4'b1011 || segments !== glyph(4'h6)) begin
      failures++;
      $display("FAIL pre_reset got an=%b seg=%h exp an=1011 seg=%h", anodes, segments, glyph(4'h6));
    end
    digits = 16'h9ABC;
    reset = 1'b1;
    step();
    checks++;
    if (anodes !== 4'hF || segments !== 8'h00 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got an=%b seg=%h fd=%b exp an=1111 seg=00 fd=0", anodes, segments, frame_done);
    end
    reset = 1'b0;
    grab_frame();
    g[0] = 8'h39; g[1] = 8'h7C; g[2] = 8'h77; g[3] = 8'h6F;
    for (int c = 0; c < 32; c++) begin
      ea = 4'hF; es = 8'h00;
      if (c % 8 >= 2) begin ea[c/8] = 1'b0; es = g[c/8]; end
      checks++;
      if (cap_an[c] !== ea || cap_sg[c] !== es || cap_fd[c] !== (c == 31)) begin
        failures++;
        $display("FAIL restart c=%0d got an=%b seg=%h fd=%b exp an=%b seg=%h fd=%b",
                 c, cap_an[c], cap_sg[c], cap_fd[c], ea, es, (c == 31));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    digits = '0; dp_in = '0; digit_en = '1; lz_suppress = 1'b0; brightness = 3'd7;
    test_reset();
    test_lz_dp();
    test_pwm();
    test_capture();
    test_digit_en();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
